// File: rtl/dac_spi_rx_if.sv
// dac_spi_rx_if: serial link inputs and decoded frame outputs of dac_spi_rx.
// DAC_SPI_RX_REGFILE_EN adds the register bank read port.
interface dac_spi_rx_if;
  logic        spi_sync;
  logic        spi_sclk;
  logic        spi_data;
  logic        frame_valid;
  logic [3:0]  frame_comm;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [15:0] frame_cnt;
`ifdef DAC_SPI_RX_REGFILE_EN
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
`endif
  modport master (
`ifdef DAC_SPI_RX_REGFILE_EN
    output rd_addr, input rd_data,
`endif
    output spi_sync, spi_sclk, spi_data,
    input  frame_valid, frame_comm, frame_addr, frame_data, frame_err, err_code, busy, frame_cnt
  );
  modport slave (
`ifdef DAC_SPI_RX_REGFILE_EN
    input rd_addr, output rd_data,
`endif
    input  spi_sync, spi_sclk, spi_data,
    output frame_valid, frame_comm, frame_addr, frame_data, frame_err, err_code, busy, frame_cnt
  );
endinterface

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: oversampling receiver/monitor for the 24-bit DAC serial link.
// DAC_SPI_RX_REGFILE_EN adds a 16x16 register bank written by command 3 frames.
module dac_spi_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic         clk,
  input logic         rst,
  dac_spi_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, ABORT} state_t;
  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync_sh, r_sclk_sh, r_data_sh;
  logic                   r_sync_q, r_sclk_q;
  logic [SYNC_STAGES:0]   r_arm;
  logic [23:0]            r_shift;
  logic [4:0]             r_bits;
  logic [31:0]            r_to;
  logic                   r_eval, r_valid, r_err;
  logic [1:0]             r_code;
  logic [3:0]             r_comm, r_addr;
  logic [15:0]            r_data, r_fcnt;
  logic                   w_sync, w_sclk, w_din, w_fall, w_start, w_end, w_tmo, w_good;
  assign w_sync  = r_sync_sh[SYNC_STAGES-1];
  assign w_sclk  = r_sclk_sh[SYNC_STAGES-1];
  assign w_din   = r_data_sh[SYNC_STAGES-1];
  assign w_fall  = r_sclk_q & ~w_sclk;
  // starts are only trusted once the reset value has drained out of the sync chain
  assign w_start = r_arm[SYNC_STAGES] & r_sync_q & ~w_sync;
  assign w_end   = ~r_sync_q & w_sync;
  assign w_tmo   = (TIMEOUT != 0) && r_state == SHIFT && !w_end && !w_fall && r_to == TIMEOUT - 1;
  assign w_good  = r_eval && r_bits == 5'd24;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync_sh <= '1;
      r_sclk_sh <= '1;
      r_data_sh <= '0;
      r_sync_q  <= 1'b1;
      r_sclk_q  <= 1'b1;
      r_arm     <= '0;
    end else begin
      r_sync_sh <= {r_sync_sh[SYNC_STAGES-2:0], bus.spi_sync};
      r_sclk_sh <= {r_sclk_sh[SYNC_STAGES-2:0], bus.spi_sclk};
      r_data_sh <= {r_data_sh[SYNC_STAGES-2:0], bus.spi_data};
      r_sync_q  <= w_sync;
      r_sclk_q  <= w_sclk;
      r_arm     <= {r_arm[SYNC_STAGES-1:0], 1'b1};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && w_start) w_state_nxt = SHIFT;
    else if (r_state != IDLE && w_end) w_state_nxt = IDLE;
    else if (w_tmo) w_state_nxt = ABORT;
  end
  // end of frame is judged one cycle later so a coincident final edge is already counted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_shift <= '0;
      r_bits  <= '0;
      r_to    <= '0;
      r_eval  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_comm  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_fcnt  <= '0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_shift <= '0;
        r_bits  <= '0;
        r_to    <= '0;
      end else if (r_state == SHIFT && w_fall) begin
        r_shift <= {r_shift[22:0], w_din};
        r_bits  <= r_bits + 5'(r_bits != 5'd25);
        r_to    <= '0;
      end else if (r_state == SHIFT) r_to <= w_tmo ? '0 : r_to + 32'd1;
      r_eval  <= r_state == SHIFT && w_end;
      r_valid <= w_good;
      r_err   <= (r_eval && !w_good) || w_tmo;
      if (w_good) begin
        r_comm <= r_shift[23:20];
        r_addr <= r_shift[19:16];
        r_data <= r_shift[15:0];
        r_fcnt <= r_fcnt + 16'd1;
      end
      if (r_eval && !w_good) r_code <= r_bits < 5'd24 ? 2'b01 : 2'b10;
      else if (w_tmo) r_code <= 2'b11;
    end
  assign bus.frame_valid = r_valid;
  assign bus.frame_err   = r_err;
  assign bus.err_code    = r_code;
  assign bus.frame_comm  = r_comm;
  assign bus.frame_addr  = r_addr;
  assign bus.frame_data  = r_data;
  assign bus.frame_cnt   = r_fcnt;
  assign bus.busy        = r_state == SHIFT;
`ifdef DAC_SPI_RX_REGFILE_EN
  logic [15:0] r_bank [16];
  // commits at the end of the valid cycle, so a same-cycle read sees the old word
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 16; i++) r_bank[i] <= '0;
    else if (r_valid && r_comm == 4'h3) r_bank[r_addr] <= r_data;
  assign bus.rd_data = r_bank[bus.rd_addr];
`endif
endmodule

// File: doc/dac_spi_rx.md
Name: dac_spi_rx

Overview:
- Receiving end of the 24-bit DAC serial link: oversamples spi_sync/spi_sclk/spi_data with the local clock.
- Frame format: 4-bit command, then 4-bit address, then 16-bit data, each field MSB first, spi_sync active low.
- Decodes the frame and presents it with a one-cycle valid strobe.
- Used as an on-board DAC model for loopback testing and as a link monitor that flags malformed frames.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each SPI input before edge detection; legal values 2-4.
- TIMEOUT, 1024: local clocks allowed between sampling edges while spi_sync is low before the frame is aborted; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- spi_sync  in  1  frame select, active low.
- spi_sclk  in  1  serial clock, idles high.
- spi_data  in  1  serial data, sampled on spi_sclk falling edge.
- frame_valid  out  1  one-cycle pulse: a good frame was received.
- frame_comm  out  4  command field of the last good frame.
- frame_addr  out  4  address field of the last good frame.
- frame_data  out  16  data field of the last good frame.
- frame_err  out  1  one-cycle pulse: a bad frame was received.
- err_code  out  2  01 short, 10 long, 11 timeout; holds its value until the next error.
- busy  out  1  high while the state is SHIFT.
- frame_cnt  out  16  count of good frames, wraps from 16'hFFFF to 0.

Behaviour:
- Input conditioning:
  - Each SPI input passes through SYNC_STAGES flip-flops, reset to sync=1, sclk=1, data=0.
  - A sampling edge is a synchronized sclk transition 1->0.
  - Sync start is a synchronized sync transition 1->0; sync end is 0->1.
- Reset: every output is 0; state IDLE; shift register, bit counter and timeout counter are 0.
- State IDLE:
  - On sync start: clear the 24-bit shift register and the 5-bit bit counter, then go to SHIFT.
  - Sclk edges while sync is high are ignored.
- State SHIFT:
  - On each sampling edge: shift the synchronized data bit in at the LSB, increment the bit counter (it saturates at 25), and clear the timeout counter.
  - Otherwise the timeout counter increments.
  - A sampling edge and sync end in the same cycle: the edge is shifted in first, then end-of-frame is evaluated with the updated count.
  - On sync end with count == 24: good frame. Next cycle:
    - frame_comm = shift[23:20], frame_addr = shift[19:16], frame_data = shift[15:0];
    - frame_valid = 1 for one cycle; frame_cnt increments.
    - Go to IDLE.
  - On sync end with count < 24: frame_err pulses, err_code = 01, frame_* unchanged, go to IDLE.
  - On sync end with count > 24: frame_err pulses, err_code = 10, go to IDLE.
  - Timeout counter reaches TIMEOUT (TIMEOUT != 0): frame_err pulses, err_code = 11, go to state ABORT.
- State ABORT: ignore all edges until sync end, then go to IDLE. No second error is reported for that frame.
- Latency: frame_valid rises SYNC_STAGES + 2 clocks after the raw spi_sync rising edge.
- Frames back-to-back with only a 1-clock sync-high gap are received; IDLE accepts a new sync start the cycle after a frame completes.
- frame_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. A frame already in progress when reset releases is ignored until the next sync start.
- Minimum supported sclk half-period: SYNC_STAGES + 1 clocks.

Optional Feature:
- Macro: DAC_SPI_RX_REGFILE_EN.
- Defined:
  - Adds ports rd_addr (in, 4) and rd_data (out, 16).
  - Adds a 16 x 16 register bank, reset to 0.
  - A good frame with frame_comm == 4'h3 writes frame_data to bank[frame_addr] in the same cycle frame_valid pulses.
  - rd_data = bank[rd_addr], combinational; a read of the address being written returns the old value that cycle.
- Undefined: no bank and no rd_* ports; all other behaviour is identical.

Test Plan:
- Good frame: send comm 4'h3, addr 4'h5, data 16'hA5C3 at a 32-clock bit period -> one frame_valid pulse; frame_comm = 3, frame_addr = 5, frame_data = A5C3; frame_cnt = 1; frame_err stays 0.
- Short frame: 23 bits, then sync high -> frame_err pulse, err_code = 01, frame_* unchanged; a following good frame (1, 2, 16'h0001) is decoded correctly.
- Long frame: 25 bits -> err_code = 10. Then hold sync low with no sclk for TIMEOUT + 5 clocks -> err_code = 11 exactly once, busy = 0 after sync rises.
- Back-to-back: three frames (data 0000, FFFF, 8001) with a 1-clock sync gap, final edge coincident with sync rise -> three valid pulses, correct data, frame_cnt = 3.
- Reset: assert rst after 12 bits of a frame, release mid-frame -> outputs 0, no valid or error pulse for that frame; the next frame decodes normally.
- Register bank, with DAC_SPI_RX_REGFILE_EN: write addr 7 = 16'h1234 with comm 3, then addr 7 = 16'h5678 with comm 2 -> rd_addr = 7 gives 16'h1234; rd_addr = 0 gives 0.
